// File: rtl/vga_rx_timing.sv
// VGA receiver timing recovery: measures line/frame lengths, locks to the expected mode and
// emits active-area pixels with coordinates. Define VGA_RX_FRAME_CKSUM_EN for a per-frame pixel checksum.
module vga_rx_timing #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_BP        = 33,
  parameter int H_TOTAL_EXP = 800,
  parameter int V_TOTAL_EXP = 525
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic        PIX_CE,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic [3:0]  VGA_R,
  input  logic [3:0]  VGA_G,
  input  logic [3:0]  VGA_B,
  output logic [9:0]  PIX_X,
  output logic [9:0]  PIX_Y,
  output logic [3:0]  PIX_R,
  output logic [3:0]  PIX_G,
  output logic [3:0]  PIX_B,
  output logic        PIX_VALID,
  output logic        FRAME_START,
  output logic        LOCKED,
  output logic [11:0] H_TOTAL,
  output logic [11:0] V_TOTAL,
  output logic [15:0] FRAME_CKSUM
);

  typedef enum logic [1:0] {
    ST_UNLOCK,
    ST_SEEK,
    ST_CHECK,
    ST_LOCK
  } lock_state_t;

  localparam logic [11:0] CNT_MAX = 12'hFFF;
  localparam logic [11:0] H_LO    = 12'(H_BP);
  localparam logic [11:0] H_HI    = 12'(H_BP + H_ACTIVE);
  localparam logic [11:0] V_LO    = 12'(V_BP);
  localparam logic [11:0] V_HI    = 12'(V_BP + V_ACTIVE);
  localparam logic [11:0] H_EXP   = 12'(H_TOTAL_EXP);
  localparam logic [11:0] V_EXP   = 12'(V_TOTAL_EXP);

  logic        hs_s1, hs_s2, vs_s1, vs_s2;
  logic [11:0] rgb_s1, rgb_s2;
  logic [11:0] hcnt, vcnt;
  logic [11:0] hcnt_inc, vcnt_inc;
  logic        hs_rise, vs_rise;
  logic        h_match, v_match;
  logic        line_bad;
  logic        frame_ok;
  logic        in_active;

  lock_state_t state_q, state_d;
  logic [1:0]  match_q, match_d;

  // Syncs are active-low, so the deassert edge is a rising edge between stage 2 and stage 1.
  assign hs_rise  = hs_s1 & ~hs_s2;
  assign vs_rise  = vs_s1 & ~vs_s2;
  assign hcnt_inc = (hcnt == CNT_MAX) ? CNT_MAX : hcnt + 12'd1;
  assign vcnt_inc = (vcnt == CNT_MAX) ? CNT_MAX : vcnt + 12'd1;
  assign h_match  = (hcnt_inc == H_EXP);
  assign v_match  = (vcnt_inc == V_EXP);

  // The line closing on the VS edge belongs to the frame being judged.
  assign frame_ok = ~line_bad & (~hs_rise | h_match) & v_match;

  assign in_active = (hcnt >= H_LO) && (hcnt < H_HI) && (vcnt >= V_LO) && (vcnt < V_HI);
  assign LOCKED    = (state_q == ST_LOCK);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      hs_s1   <= 1'b1;
      hs_s2   <= 1'b1;
      vs_s1   <= 1'b1;
      vs_s2   <= 1'b1;
      rgb_s1  <= '0;
      rgb_s2  <= '0;
      hcnt    <= '0;
      vcnt    <= '0;
      H_TOTAL <= '0;
      V_TOTAL <= '0;
    end else if (PIX_CE) begin
      hs_s1  <= VGA_HS;
      hs_s2  <= hs_s1;
      vs_s1  <= VGA_VS;
      vs_s2  <= vs_s1;
      rgb_s1 <= {VGA_R, VGA_G, VGA_B};
      rgb_s2 <= rgb_s1;
      hcnt   <= hs_rise ? 12'd0 : hcnt_inc;
      if (vs_rise)      vcnt <= 12'd0;
      else if (hs_rise) vcnt <= vcnt_inc;
      if (hs_rise) H_TOTAL <= hcnt_inc;
      if (vs_rise) V_TOTAL <= vcnt_inc;
    end
  end

  // Second pipeline stage: hcnt/vcnt and rgb_s2 describe the same sample here.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      PIX_VALID <= 1'b0;
      PIX_X     <= '0;
      PIX_Y     <= '0;
      PIX_R     <= '0;
      PIX_G     <= '0;
      PIX_B     <= '0;
    end else if (PIX_CE) begin
      PIX_VALID <= in_active & LOCKED;
      PIX_X     <= in_active ? 10'(hcnt - H_LO) : 10'd0;
      PIX_Y     <= in_active ? 10'(vcnt - V_LO) : 10'd0;
      if (in_active && LOCKED) begin
        PIX_R <= rgb_s2[11:8];
        PIX_G <= rgb_s2[7:4];
        PIX_B <= rgb_s2[3:0];
      end else begin
        PIX_R <= '0;
        PIX_G <= '0;
        PIX_B <= '0;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      FRAME_START <= 1'b0;
      line_bad    <= 1'b0;
    end else begin
      FRAME_START <= PIX_CE & vs_rise;
      if (PIX_CE) begin
        if (vs_rise)                line_bad <= 1'b0;
        else if (hs_rise && !h_match) line_bad <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q <= ST_UNLOCK;
      match_q <= '0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    unique case (state_q)
      ST_UNLOCK: begin
        state_d = ST_SEEK;
        match_d = '0;
      end
      ST_SEEK: begin
        if (PIX_CE && vs_rise) begin
          state_d = ST_CHECK;
          match_d = '0;
        end
      end
      ST_CHECK: begin
        if (PIX_CE && vs_rise) begin
          if (!frame_ok) begin
            match_d = '0;
          end else if (match_q == 2'd1) begin
            match_d = 2'd2;
            state_d = ST_LOCK;
          end else begin
            match_d = match_q + 2'd1;
          end
        end
      end
      ST_LOCK: begin
        if ((PIX_CE && hs_rise && !h_match) || (PIX_CE && vs_rise && !v_match) ||
            (hcnt == CNT_MAX)) begin
          state_d = ST_SEEK;
          match_d = '0;
        end
      end
      default: begin
        state_d = ST_UNLOCK;
        match_d = '0;
      end
    endcase
  end

`ifdef VGA_RX_FRAME_CKSUM_EN
  logic [15:0] cksum_acc;
  logic        out_stb;
  logic [15:0] pix_word;

  // out_stb marks the cycle in which a freshly registered output pixel is presented.
  assign pix_word = PIX_VALID ? {4'h0, PIX_R, PIX_G, PIX_B} : 16'h0000;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      out_stb     <= 1'b0;
      cksum_acc   <= '0;
      FRAME_CKSUM <= '0;
    end else begin
      out_stb <= PIX_CE;
      if (out_stb) begin
        if (FRAME_START) begin
          FRAME_CKSUM <= cksum_acc;
          cksum_acc   <= pix_word;
        end else begin
          cksum_acc <= cksum_acc + pix_word;
        end
      end
    end
  end
`else
  assign FRAME_CKSUM = 16'h0000;
`endif

endmodule

// File: doc/vga_rx_timing.md
VGA_RX_TIMING -- requirements
Module: vga_rx_timing

Interface
REQ-001 Parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 Parameter H_BP, default 48: PIX_CE ticks from HS deassert to first active pixel.
REQ-003 Parameter V_ACTIVE, default 480: active lines per frame.
REQ-004 Parameter V_BP, default 33: lines from VS deassert to first active line.
REQ-005 Parameter H_TOTAL_EXP, default 800: expected ticks per line.
REQ-006 Parameter V_TOTAL_EXP, default 525: expected lines per frame.
REQ-007 CLOCK_50  in  1: single system clock; all logic on its rising edge.
REQ-008 RESET  in  1: synchronous reset, active-high.
REQ-009 PIX_CE  in  1: pixel-clock enable; inputs are sampled and counters advance only on cycles where it is 1.
REQ-010 VGA_HS  in  1: horizontal sync, active-low.
REQ-011 VGA_VS  in  1: vertical sync, active-low.
REQ-012 VGA_R, VGA_G, VGA_B  in  4 each: pixel colour.
REQ-013 PIX_X, PIX_Y  out  10 each: coordinate of the pixel on PIX_R/G/B.
REQ-014 PIX_R, PIX_G, PIX_B  out  4 each: registered colour.
REQ-015 PIX_VALID  out  1: active-area pixel, qualified by lock.
REQ-016 FRAME_START  out  1: one-cycle pulse on VS deassert edge.
REQ-017 LOCKED  out  1: timing matches expected totals.
REQ-018 H_TOTAL, V_TOTAL  out  12 each: last measured line and frame lengths.
REQ-019 FRAME_CKSUM  out  16: per-frame pixel checksum; see Configuration.

Function
REQ-020 On each PIX_CE tick the block SHALL register HS, VS and RGB into stage 1 and detect edges by comparing stage 1 with stage 2.
REQ-021 hcnt (12 bit) SHALL clear to 0 on the HS rising edge, increment otherwise, and saturate at 4095.
REQ-022 vcnt (12 bit) SHALL clear to 0 on the VS rising edge, increment on each HS rising edge, and saturate at 4095; VS edge wins if both occur on the same tick.
REQ-023 On the HS rising edge, H_TOTAL SHALL latch hcnt+1; on the VS rising edge, V_TOTAL SHALL latch vcnt+1.
REQ-024 Active area: H_BP <= hcnt < H_BP+H_ACTIVE and V_BP <= vcnt < V_BP+V_ACTIVE; then PIX_X = hcnt-H_BP and PIX_Y = vcnt-V_BP, else both 0.
REQ-025 PIX_VALID SHALL equal active-area AND LOCKED, delivered 2 PIX_CE ticks after the corresponding input sample, aligned with PIX_R/G/B/X/Y.
REQ-026 Outside PIX_VALID, PIX_R/G/B SHALL be 0.
REQ-027 FRAME_START SHALL pulse for exactly one CLOCK_50 cycle on the tick where the VS rising edge is detected.
REQ-028 Lock FSM states: UNLOCK, SEEK, CHECK, LOCK.
REQ-029 UNLOCK -> SEEK after reset exit.
REQ-030 SEEK -> CHECK on first VS rising edge; match count cleared.
REQ-031 CHECK: at each VS rising edge, if V_TOTAL == V_TOTAL_EXP and every line in that frame had H_TOTAL == H_TOTAL_EXP, increment match count, else clear it; reaching 2 -> LOCK.
REQ-032 LOCK -> SEEK on any line or frame length mismatch, or on hcnt reaching 4095 (sync loss); LOCKED SHALL fall the cycle after detection.
REQ-033 LOCKED SHALL be 1 only in state LOCK.

Reset
REQ-034 While RESET = 1 on a clock edge: all counters, pipeline stages and outputs SHALL be 0, except sync stages, which SHALL be 1 (idle); FSM SHALL go to UNLOCK.
REQ-035 RESET mid-frame SHALL discard partial measurements; re-lock SHALL require SEEK plus 2 full matching frames.

Configuration
REQ-036 Macro VGA_RX_FRAME_CKSUM_EN defined: a 16-bit accumulator SHALL add {R,G,B} (12 bits, zero-extended) for each PIX_VALID pixel, modulo 2^16. On FRAME_START it SHALL copy its value to FRAME_CKSUM and clear, with the pixel of that tick, if any, starting the new sum.
REQ-037 Macro VGA_RX_FRAME_CKSUM_EN undefined: FRAME_CKSUM SHALL be constant 0 and no accumulator SHALL exist.

Verification
REQ-038 800x525 default timing, PIX_CE every 2nd cycle -> LOCKED rises at the 3rd VS rising edge; H_TOTAL = 800, V_TOTAL = 525.
REQ-039 Locked; drive RGB = 4'hF only at input hcnt 248..347, vcnt 233..332 -> PIX_VALID with RGB F exactly for PIX_X 200..299, PIX_Y 200..299, two ticks later.
REQ-040 Locked; one line of 799 ticks -> LOCKED falls within 1 cycle of that HS edge; relocks after 2 further good frames.
REQ-041 Locked; HS held high for 4096 ticks -> hcnt saturates at 4095, LOCKED = 0, PIX_VALID = 0.
REQ-042 RESET for 1 cycle mid-line -> all outputs 0 next cycle and FSM in UNLOCK.
REQ-043 VGA_RX_FRAME_CKSUM_EN defined; locked; all active pixels RGB = 12'h001 -> FRAME_CKSUM = 307200 mod 65536 = 16'hB000 after the next FRAME_START.
